// File: rtl/car_light_pkg.sv
// Shared definitions for the tail-light status path.
//   - bit positions inside the 4-bit car_status word
//   - turn-signal FSM state encoding
package car_light_pkg;

    localparam int unsigned STATUS_W = 4;

    // car_status bit indices: {brake, hazard, right, left}
    localparam int unsigned BRAKE  = 3;
    localparam int unsigned HAZARD = 2;
    localparam int unsigned RIGHT  = 1;
    localparam int unsigned LEFT   = 0;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } turn_state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one asynchronous, bouncy input.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : raw asynchronous input
//   dout       : debounced level
//   rise       : one-cycle pulse on a debounced 0->1 transition
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;

    // Accept the synchronized value only after it has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], din};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign dout = stable_q;
    assign rise = rise_q;

endmodule

// File: rtl/car_status_gen.sv
// Builds the car_status word for the tail-light controller from the
// board's turn/hazard buttons and brake switch.
//   clk, rst_n      : clock, synchronous active-low reset
//   btn_left/right  : turn buttons (async, bouncy, active-high)
//   btn_hazard      : hazard button (async, bouncy, active-high)
//   sw_brake        : brake switch level (async, bouncy, active-high)
//   car_status      : registered {brake, hazard, right, left}
//   status_changed  : one-cycle pulse when car_status loads a new value
module car_status_gen
    import car_light_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_OFF_CYCLES = 500_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_hazard,
    input  logic                sw_brake,
    output logic [STATUS_W-1:0] car_status,
    output logic                status_changed
);

    localparam int unsigned TMR_W = $clog2(AUTO_OFF_CYCLES);

    logic left_lvl, left_rise;
    logic right_lvl, right_rise;
    logic haz_lvl, haz_rise;
    logic brake_lvl, brake_rise;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst_n(rst_n), .din(btn_left), .dout(left_lvl), .rise(left_rise)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst_n(rst_n), .din(btn_right), .dout(right_lvl), .rise(right_rise)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
        .clk(clk), .rst_n(rst_n), .din(btn_hazard), .dout(haz_lvl), .rise(haz_rise)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brake (
        .clk(clk), .rst_n(rst_n), .din(sw_brake), .dout(brake_lvl), .rise(brake_rise)
    );

    // A rise pulse only ever occurs with the debounced level already high,
    // so qualifying with the level changes nothing functionally.
    logic left_press, right_press, haz_press, brake_now;
    assign left_press  = left_rise  & left_lvl;
    assign right_press = right_rise & right_lvl;
    assign haz_press   = haz_rise   & haz_lvl;
    assign brake_now   = brake_lvl  | brake_rise;

    turn_state_e         turn_q;
    logic                turn_chg_q;
    logic [TMR_W-1:0]    timer_q;
    logic                hazard_q;
    logic                brake_q;
    logic                expire_c;
    logic [STATUS_W-1:0] status_c;

    // The timer restarts the cycle after any state change, so the turn
    // signal is visible for AUTO_OFF_CYCLES+1 cycles before self-cancel.
    always_comb begin
        expire_c = 1'b0;
        if ((turn_q != ST_OFF) && !turn_chg_q &&
            (timer_q == TMR_W'(AUTO_OFF_CYCLES - 1))) begin
            expire_c = 1'b1;
        end
    end

    // Output word; hazard masks the turn bits, so 11 is never produced.
    always_comb begin
        status_c         = '0;
        status_c[BRAKE]  = brake_q;
        status_c[HAZARD] = hazard_q;
        if (!hazard_q) begin
            case (turn_q)
                ST_LEFT:  status_c[LEFT]  = 1'b1;
                ST_RIGHT: status_c[RIGHT] = 1'b1;
                default:  ;
            endcase
        end
    end

    // Turn FSM, auto-off timer, hazard/brake flags and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            turn_q         <= ST_OFF;
            turn_chg_q     <= 1'b0;
            timer_q        <= '0;
            hazard_q       <= 1'b0;
            brake_q        <= 1'b0;
            car_status     <= '0;
            status_changed <= 1'b0;
        end else begin
            turn_chg_q <= 1'b0;
            if (left_press && !right_press) begin
                turn_q     <= (turn_q == ST_LEFT) ? ST_OFF : ST_LEFT;
                turn_chg_q <= 1'b1;
            end else if (right_press && !left_press) begin
                turn_q     <= (turn_q == ST_RIGHT) ? ST_OFF : ST_RIGHT;
                turn_chg_q <= 1'b1;
            end else if (expire_c) begin
                turn_q     <= ST_OFF;
                turn_chg_q <= 1'b1;
            end

            if (turn_chg_q || (turn_q == ST_OFF)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end

            if (haz_press) begin
                hazard_q <= ~hazard_q;
            end
            brake_q <= brake_now;

            car_status     <= status_c;
            status_changed <= (status_c != car_status);
        end
    end

endmodule

// File: tb/tb_car_status_gen.sv
module tb_car_status_gen;

    localparam int unsigned D = 4;
    localparam int unsigned A = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_hazard = 1'b0;
    logic       sw_brake = 1'b0;
    logic [3:0] car_status;
    logic       status_changed;

    car_status_gen #(.DEBOUNCE_CYCLES(D), .AUTO_OFF_CYCLES(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_hazard(btn_hazard), .sw_brake(sw_brake),
        .car_status(car_status), .status_changed(status_changed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        logic [3:0] word;
    } exp_t;
    exp_t sb[$];

    // ---------------- reference model ----------------
    // Inputs are viewed as sample streams: a level is accepted once the D
    // samples taken two to D+1 edges ago all agree and differ from the
    // accepted level. Presses act one edge later; the word shows one edge
    // after that. A turn signal entered at edge e self-cancels at e+A+1.
    bit       hist[4][$];
    bit       m_stable[4];
    bit [2:0] m_pp;
    int       m_turn;      // 0 off, 1 left, 2 right
    int       m_entered;
    bit       m_haz, m_brake;
    logic [3:0] m_last;
    int       m_rst_at = -1;

    always @(posedge clk) begin
        logic [3:0] smp;
        logic [3:0] w;
        logic [1:0] tb_bits;
        bit [3:0]   rise;
        bit         v, ok;
        cyc = cyc + 1;
        smp = {sw_brake, btn_hazard, btn_right, btn_left};
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hist[i].delete();
                for (int k = 0; k < int'(D) + 2; k++) hist[i].push_back(1'b0);
                m_stable[i] = 1'b0;
            end
            m_pp = '0; m_turn = 0; m_entered = 0;
            m_haz = 1'b0; m_brake = 1'b0; m_last = 4'h0;
            sb.delete();
            m_rst_at = cyc;
        end else begin
            if (m_pp[0] && !m_pp[1]) begin
                m_turn = (m_turn == 1) ? 0 : 1; m_entered = cyc;
            end else if (m_pp[1] && !m_pp[0]) begin
                m_turn = (m_turn == 2) ? 0 : 2; m_entered = cyc;
            end else if (m_turn != 0 && (cyc - m_entered) == int'(A) + 1) begin
                m_turn = 0;
            end
            if (m_pp[2]) m_haz = ~m_haz;
            m_brake = m_stable[3];

            for (int i = 0; i < 4; i++) begin
                hist[i].push_back(smp[i]);
                void'(hist[i].pop_front());
                v  = hist[i][0];
                ok = (v != m_stable[i]);
                for (int k = 1; k < int'(D); k++) if (hist[i][k] != v) ok = 1'b0;
                rise[i] = ok && v;
                if (ok) m_stable[i] = v;
            end
            m_pp = rise[2:0];

            tb_bits = (m_turn == 1) ? 2'b01 : (m_turn == 2) ? 2'b10 : 2'b00;
            w = {m_brake, m_haz, m_haz ? 2'b00 : tb_bits};
            if (w != m_last) begin
                sb.push_back('{cyc + 1, w});
                m_last = w;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] mon_prev = 4'h0;

    always @(negedge clk) begin
        exp_t e;
        if (m_rst_at >= 0) begin
            if (m_rst_at == cyc) begin
                checks++;
                if (car_status !== 4'h0 || status_changed !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d got status=%b chg=%b want 0000/0",
                             cyc, car_status, status_changed);
                end
            end else begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    checks++; errors++;
                    $display("FAIL missed_update cyc=%0d got status=%b want %b at cyc %0d",
                             cyc, car_status, e.word, e.due);
                end
                checks++;
                if (status_changed) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change cyc=%0d got status=%b want no change",
                                 cyc, car_status);
                    end else begin
                        e = sb.pop_front();
                        pops++;
                        if (e.due != cyc || e.word !== car_status) begin
                            errors++;
                            $display("FAIL status_update cyc=%0d got %b want %b at cyc %0d",
                                     cyc, car_status, e.word, e.due);
                        end
                    end
                end else if (car_status !== mon_prev || car_status[1:0] == 2'b11) begin
                    errors++;
                    $display("FAIL silent_change cyc=%0d got %b want %b",
                             cyc, car_status, mon_prev);
                end
            end
            mon_prev = car_status;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_btns(input logic [2:0] m);
        btn_left   = m[0];
        btn_right  = m[1];
        btn_hazard = m[2];
    endtask

    task automatic push(input logic [2:0] m, input int hold, input bit bouncy);
        if (bouncy) begin
            repeat ($urandom_range(0, 3)) begin
                drive_btns(m);
                tick($urandom_range(1, D - 1));
                drive_btns(3'b000);
                tick(1);
            end
        end
        drive_btns(m);
        tick(hold);
        drive_btns(3'b000);
        tick(D + 6);
    endtask

    initial begin
        logic [2:0] m;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // left press then toggle off
        push(3'b001, 10, 1'b0);
        push(3'b001, 6, 1'b0);

        // bouncing right button, then a clean hold
        repeat (3) begin
            btn_right = 1'b1; tick(3);
            btn_right = 1'b0; tick(1);
        end
        btn_right = 1'b1; tick(8);
        btn_right = 1'b0; tick(D + 6);
        push(3'b010, 6, 1'b0);                 // back to OFF

        // left -> right switch, off, then simultaneous press from OFF
        push(3'b001, 6, 1'b0);
        push(3'b010, 6, 1'b0);
        push(3'b010, 6, 1'b0);
        push(3'b011, 6, 1'b0);

        // hazard masks and then restores LEFT
        push(3'b001, 6, 1'b0);
        push(3'b100, 6, 1'b0);
        push(3'b100, 6, 1'b0);
        push(3'b001, 6, 1'b0);

        // auto-off with brake held
        sw_brake = 1'b1;
        push(3'b010, 6, 1'b0);
        tick(A + 20);

        // reset while RIGHT + hazard, left held through reset
        push(3'b010, 6, 1'b0);
        push(3'b100, 6, 1'b0);
        btn_left = 1'b1;
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; tick(14);
        btn_left = 1'b0; tick(D + 6);
        sw_brake = 1'b0; tick(D + 6);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    m = 3'($urandom_range(1, 7));
                    push(m, $urandom_range(1, 12), 1'($urandom_range(0, 1)));
                end
                5: begin sw_brake = ~sw_brake; tick($urandom_range(1, 10)); end
                6: begin sw_brake = ~sw_brake; tick(1); sw_brake = ~sw_brake; tick(5); end
                7: tick($urandom_range(A - 10, A + 30));
                8: tick($urandom_range(0, 20));
                default: begin
                    if ($urandom_range(0, 2) == 0) begin
                        rst_n = 1'b0; tick(1); rst_n = 1'b1;
                    end
                    tick(3);
                end
            endcase
        end

        drive_btns(3'b000);
        tick(D + 20);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        checks++;
        if (pops < 15) begin
            errors++;
            $display("FAIL update_count got %0d want >= 15", pops);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
